// File: rtl/kempston_mouse_pkg.sv
// rtl/kempston_mouse_pkg.sv - shared constants and types for the Kempston mouse front-end
package kempston_mouse_pkg;

   typedef enum logic [2:0] {
      INIT_WAIT,
      TX_RTS,
      TX_DATA,
      TX_ACK,
      WAIT_FA,
      STREAM
   } mouse_state_t;

   localparam logic [7:0] KMOUSE_PORT_LO = 8'hDF;
   localparam logic [7:0] KMOUSE_X_HI    = 8'hFB;
   localparam logic [7:0] KMOUSE_Y_HI    = 8'hFF;
   localparam logic [7:0] KMOUSE_BTN_HI  = 8'hFA;

   localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
   localparam logic [7:0] PS2_ACK        = 8'hFA;

   // Parity bit that makes the 9-bit {data, parity} word carry an odd number of ones.
   function automatic logic odd_parity(input logic [7:0] b);
      return ~^b;
   endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 line conditioning and 11-bit device-to-host frame receiver
module ps2_frame_rx #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 56_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_en,
   input  logic       ps2_clk_in,
   input  logic       ps2_dat_in,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       clk_fall,
   output logic       dat_filt
);

   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   logic [1:0]    meta;
   logic [1:0]    sync;
   logic [1:0]    filt;
   logic [FW-1:0] fcnt [2];
   logic          clk_q;

   logic [3:0]    bit_cnt;
   logic [7:0]    sr;
   logic          par;
   logic [TW-1:0] gap;

   // Index 0 is the clock line, index 1 the data line; both idle high.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta    <= 2'b11;
         sync    <= 2'b11;
         filt    <= 2'b11;
         fcnt[0] <= '0;
         fcnt[1] <= '0;
         clk_q   <= 1'b1;
      end else begin
         meta  <= {ps2_dat_in, ps2_clk_in};
         sync  <= meta;
         clk_q <= filt[0];
         for (int i = 0; i < 2; i++) begin
            if (sync[i] == filt[i]) begin
               fcnt[i] <= '0;
            end else if (fcnt[i] == FW'(FILTER_LEN - 1)) begin
               filt[i] <= sync[i];
               fcnt[i] <= '0;
            end else begin
               fcnt[i] <= fcnt[i] + 1'b1;
            end
         end
      end
   end

   assign clk_fall = clk_q & ~filt[0];
   assign dat_filt = filt[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt    <= '0;
         sr         <= '0;
         par        <= 1'b0;
         gap        <= '0;
         rx_byte    <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (!rx_en) begin
            bit_cnt <= '0;
            gap     <= '0;
         end else if (clk_fall) begin
            gap <= '0;
            if (bit_cnt == 4'd0) begin
               if (!dat_filt) bit_cnt <= 4'd1;
               else           frame_err <= 1'b1;
            end else if (bit_cnt <= 4'd8) begin
               sr      <= {dat_filt, sr[7:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
               par     <= dat_filt;
               bit_cnt <= 4'd10;
            end else begin
               bit_cnt <= '0;
               if (dat_filt && (^{sr, par})) begin
                  rx_byte    <= sr;
                  byte_valid <= 1'b1;
               end else begin
                  frame_err <= 1'b1;
               end
            end
         end else if (bit_cnt != 4'd0) begin
            // A stalled device must not leave half a frame to be merged with the next one.
            if (gap == TW'(TIMEOUT)) begin
               bit_cnt   <= '0;
               gap       <= '0;
               frame_err <= 1'b1;
            end else begin
               gap <= gap + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/kempston_mouse.sv
// rtl/kempston_mouse.sv - PS/2 mouse to Kempston mouse I/O ports (FBDF/FFDF/FADF)
module kempston_mouse
   import kempston_mouse_pkg::*;
#(
   parameter int CLK_FREQ   = 28_000_000,
   parameter int INIT_DELAY = CLK_FREQ / 2,
   parameter int RTS_CYCLES = CLK_FREQ / 10_000,
   parameter int TIMEOUT    = CLK_FREQ / 500,
   parameter int FILTER_LEN = 8
) (
   input  logic        clk28,
   input  logic        rst,
   input  logic        en,
   input  logic        ps2_clk_in,
   input  logic        ps2_dat_in,
   output logic        ps2_clk_oe,
   output logic        ps2_dat_oe,
   input  logic [15:0] bus_a,
   input  logic        bus_ioreq,
   input  logic        bus_rd,
   output logic [7:0]  d_out,
   output logic        d_out_active,
   output logic        streaming
);

   localparam logic [31:0] INIT_LAST = 32'(INIT_DELAY - 1);
   localparam logic [31:0] RTS_LAST  = 32'(RTS_CYCLES - 1);
   localparam logic [31:0] TO_LAST   = 32'(TIMEOUT - 1);
   localparam logic [31:0] FA_LAST   = 32'(5 * TIMEOUT - 1);

   localparam logic [2:0] X_SEL   = KMOUSE_X_HI[2:0];
   localparam logic [2:0] Y_SEL   = KMOUSE_Y_HI[2:0];
   localparam logic [2:0] BTN_SEL = KMOUSE_BTN_HI[2:0];

   mouse_state_t state, state_n;
   logic [31:0]  timer, timer_n;
   logic [3:0]   tx_idx, tx_idx_n;
   logic         clk_oe_n, dat_oe_n;

   logic [7:0]   rx_byte;
   logic         byte_valid, frame_err, clk_fall, dat_filt, rx_en;

   logic [7:0]   x, y, buttons, dx, dy;
   logic [4:0]   hdr;
   logic [1:0]   pkt_idx;
   logic         commit;
   logic         unused_hi_addr;

   assign rx_en     = (state == WAIT_FA) || (state == STREAM);
   assign streaming = (state == STREAM);

   ps2_frame_rx #(
      .FILTER_LEN (FILTER_LEN),
      .TIMEOUT    (TIMEOUT)
   ) u_rx (
      .clk        (clk28),
      .rst        (rst),
      .rx_en      (rx_en),
      .ps2_clk_in (ps2_clk_in),
      .ps2_dat_in (ps2_dat_in),
      .rx_byte    (rx_byte),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
      .clk_fall   (clk_fall),
      .dat_filt   (dat_filt)
   );

   always_ff @(posedge clk28) begin
      if (rst) begin
         state      <= INIT_WAIT;
         timer      <= '0;
         tx_idx     <= '0;
         ps2_clk_oe <= 1'b0;
         ps2_dat_oe <= 1'b0;
      end else begin
         state      <= state_n;
         timer      <= timer_n;
         tx_idx     <= tx_idx_n;
         ps2_clk_oe <= clk_oe_n;
         ps2_dat_oe <= dat_oe_n;
      end
   end

   always_comb begin
      state_n  = state;
      timer_n  = timer + 32'd1;
      tx_idx_n = tx_idx;
      clk_oe_n = ps2_clk_oe;
      dat_oe_n = ps2_dat_oe;
      case (state)
         INIT_WAIT: begin
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
            tx_idx_n = '0;
            if (timer == INIT_LAST) begin
               state_n  = TX_RTS;
               timer_n  = '0;
               clk_oe_n = 1'b1;
            end
         end
         TX_RTS: begin
            if (timer == RTS_LAST) begin
               state_n  = TX_DATA;
               timer_n  = '0;
               clk_oe_n = 1'b0;
               dat_oe_n = 1'b1;
               tx_idx_n = '0;
            end
         end
         TX_DATA: begin
            // The device clocks each host bit out; the next bit is presented while clk is low.
            if (clk_fall) begin
               timer_n  = '0;
               tx_idx_n = tx_idx + 4'd1;
               if (tx_idx < 4'd8) begin
                  dat_oe_n = ~PS2_CMD_ENABLE[tx_idx[2:0]];
               end else if (tx_idx == 4'd8) begin
                  dat_oe_n = ~odd_parity(PS2_CMD_ENABLE);
               end else begin
                  dat_oe_n = 1'b0;
                  state_n  = TX_ACK;
               end
            end else if (timer == TO_LAST) begin
               state_n  = INIT_WAIT;
               timer_n  = '0;
               clk_oe_n = 1'b0;
               dat_oe_n = 1'b0;
            end
         end
         TX_ACK: begin
            if (clk_fall) begin
               timer_n = '0;
               state_n = dat_filt ? INIT_WAIT : WAIT_FA;
            end else if (timer == TO_LAST) begin
               state_n = INIT_WAIT;
               timer_n = '0;
            end
         end
         WAIT_FA: begin
            if (byte_valid && (rx_byte == PS2_ACK)) begin
               state_n = STREAM;
               timer_n = '0;
            end else if (timer == FA_LAST) begin
               state_n = INIT_WAIT;
               timer_n = '0;
            end
         end
         STREAM: begin
            timer_n = timer;
         end
         default: begin
            state_n  = INIT_WAIT;
            timer_n  = '0;
            clk_oe_n = 1'b0;
            dat_oe_n = 1'b0;
         end
      endcase
   end

   // hdr keeps only the header bits the commit needs: {y_ovf, x_ovf, mid, right, left}.
   always_ff @(posedge clk28) begin
      if (rst) begin
         x       <= '0;
         y       <= '0;
         buttons <= 8'hFF;
         hdr     <= '0;
         dx      <= '0;
         dy      <= '0;
         pkt_idx <= '0;
         commit  <= 1'b0;
      end else begin
         commit <= 1'b0;
         if (commit) begin
            if (!hdr[3]) x <= x + dx;
            if (!hdr[4]) y <= y + dy;
            buttons <= {5'b11111, ~hdr[2], ~hdr[0], ~hdr[1]};
         end
         if ((state != STREAM) || frame_err) begin
            pkt_idx <= '0;
         end else if (byte_valid) begin
            case (pkt_idx)
               2'd0: begin
                  if (rx_byte[3]) begin
                     hdr     <= {rx_byte[7:6], rx_byte[2:0]};
                     pkt_idx <= 2'd1;
                  end
               end
               2'd1: begin
                  dx      <= rx_byte;
                  pkt_idx <= 2'd2;
               end
               2'd2: begin
                  dy      <= rx_byte;
                  pkt_idx <= 2'd0;
                  commit  <= 1'b1;
               end
               default: pkt_idx <= 2'd0;
            endcase
         end
      end
   end

   assign unused_hi_addr = &{1'b0, bus_a[15:11]};

   always_comb begin
      d_out        = 8'hFF;
      d_out_active = 1'b0;
      if (en && bus_ioreq && bus_rd && (bus_a[7:0] == KMOUSE_PORT_LO)) begin
         case (bus_a[10:8])
            X_SEL: begin
               d_out        = x;
               d_out_active = 1'b1;
            end
            Y_SEL: begin
               d_out        = y;
               d_out_active = 1'b1;
            end
            BTN_SEL: begin
               d_out        = buttons;
               d_out_active = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_kempston_mouse.sv
// tb/tb_kempston_mouse.sv - bench for kempston_mouse with a PS/2 device model and read scoreboard
module tb_kempston_mouse;

   localparam int INIT_DELAY = 300;
   localparam int RTS_CYCLES = 60;
   localparam int TIMEOUT    = 500;
   localparam int FILTER_LEN = 4;
   localparam int HALF       = 20;

   logic        clk28 = 1'b0;
   logic        rst, en, dev_clk, dev_dat;
   logic        ps2_clk_in, ps2_dat_in, ps2_clk_oe, ps2_dat_oe;
   logic [15:0] bus_a;
   logic        bus_ioreq, bus_rd;
   logic [7:0]  d_out;
   logic        d_out_active, streaming;

   always #5 clk28 = ~clk28;

   assign ps2_clk_in = dev_clk & ~ps2_clk_oe;
   assign ps2_dat_in = dev_dat & ~ps2_dat_oe;

   kempston_mouse #(
      .CLK_FREQ   (28_000_000),
      .INIT_DELAY (INIT_DELAY),
      .RTS_CYCLES (RTS_CYCLES),
      .TIMEOUT    (TIMEOUT),
      .FILTER_LEN (FILTER_LEN)
   ) dut (
      .clk28        (clk28),
      .rst          (rst),
      .en           (en),
      .ps2_clk_in   (ps2_clk_in),
      .ps2_dat_in   (ps2_dat_in),
      .ps2_clk_oe   (ps2_clk_oe),
      .ps2_dat_oe   (ps2_dat_oe),
      .bus_a        (bus_a),
      .bus_ioreq    (bus_ioreq),
      .bus_rd       (bus_rd),
      .d_out        (d_out),
      .d_out_active (d_out_active),
      .streaming    (streaming)
   );

   typedef struct {
      string       tag;
      logic [15:0] addr;
      logic        en;
      logic        act;
      logic [7:0]  data;
   } rd_exp_t;

   rd_exp_t    sb[$];
   int         errors = 0;
   int         checks = 0;
   logic [7:0] mdl_x, mdl_y, mdl_btn;
   longint     t_rel;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_range(input string tag, input int v, input int lo, input int hi);
      check($sformatf("%s (%0d cycles, want %0d..%0d)", tag, v, lo, hi), 32'(v >= lo && v <= hi), 32'd1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk28);
   endtask

   task automatic expect_read(input string tag, input logic [15:0] a, input logic e,
                              input logic act, input logic [7:0] d);
      rd_exp_t t;
      t.tag = tag; t.addr = a; t.en = e; t.act = act; t.data = d;
      sb.push_back(t);
   endtask

   task automatic push_regs(input string tag);
      expect_read({tag, " x"},   16'hFBDF, 1'b1, 1'b1, mdl_x);
      expect_read({tag, " y"},   16'hFFDF, 1'b1, 1'b1, mdl_y);
      expect_read({tag, " btn"}, 16'hFADF, 1'b1, 1'b1, mdl_btn);
   endtask

   task automatic drain();
      rd_exp_t t;
      while (sb.size() > 0) begin
         t = sb.pop_front();
         @(negedge clk28);
         bus_a = t.addr; en = t.en; bus_ioreq = 1'b1; bus_rd = 1'b1;
         #1;
         check({t.tag, " active"}, 32'(d_out_active), 32'(t.act));
         check({t.tag, " data"},   32'(d_out),        32'(t.data));
         @(negedge clk28);
         bus_ioreq = 1'b0; bus_rd = 1'b0; en = 1'b1;
      end
   endtask

   task automatic dev_send(input logic [7:0] b, input logic bad_par);
      logic [10:0] f;
      f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         dev_dat = f[i];
         wait_cycles(HALF);
         dev_clk = 1'b0;
         wait_cycles(HALF);
         dev_clk = 1'b1;
      end
      dev_dat = 1'b1;
      wait_cycles(60);
   endtask

   task automatic dev_partial(input int nbits);
      for (int i = 0; i < nbits; i++) begin
         dev_dat = (i == 0) ? 1'b0 : 1'b1;
         wait_cycles(HALF);
         dev_clk = 1'b0;
         wait_cycles(HALF);
         dev_clk = 1'b1;
      end
      dev_dat = 1'b1;
      wait_cycles(TIMEOUT + 100);
   endtask

   task automatic model_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      if (!b0[6]) mdl_x = mdl_x + b1;
      if (!b0[7]) mdl_y = mdl_y + b2;
      mdl_btn = {5'b11111, ~b0[2], ~b0[0], ~b0[1]};
   endtask

   task automatic send_packet(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2);
      dev_send(b0, 1'b0);
      dev_send(b1, 1'b0);
      dev_send(b2, 1'b0);
      model_packet(b0, b1, b2);
      push_regs(tag);
      drain();
   endtask

   task automatic wait_clk_oe();
      int n = 0;
      while (!ps2_clk_oe && n < INIT_DELAY + 200) begin
         @(negedge clk28);
         n++;
      end
   endtask

   task automatic measure_rts();
      int n = 0;
      while (ps2_clk_oe && n < RTS_CYCLES + 100) begin
         @(negedge clk28);
         n++;
      end
      check_range("rts length", n, RTS_CYCLES - 1, RTS_CYCLES + 1);
      check("start bit driven", 32'(ps2_dat_oe), 32'd1);
   endtask

   task automatic host_handshake();
      logic [9:0] rx;
      wait_clk_oe();
      check_range("init delay", int'(($time - t_rel) / 10), INIT_DELAY - 2, INIT_DELAY + 2);
      measure_rts();
      wait_cycles(HALF);
      for (int i = 0; i < 10; i++) begin
         dev_clk = 1'b0;
         wait_cycles(HALF);
         dev_clk = 1'b1;
         wait_cycles(10);
         rx[i] = ps2_dat_in;
         wait_cycles(10);
      end
      check("tx command byte", 32'(rx[7:0]), 32'h0000_00F4);
      check("tx parity bit",   32'(rx[8]),   32'd0);
      check("tx stop bit",     32'(rx[9]),   32'd1);
      dev_dat = 1'b0;
      wait_cycles(10);
      dev_clk = 1'b0;
      wait_cycles(HALF);
      dev_clk = 1'b1;
      wait_cycles(10);
      dev_dat = 1'b1;
      wait_cycles(40);
   endtask

   task automatic watch_commit(input logic [7:0] old_v, input logic [7:0] new_v);
      logic [7:0] first, v;
      int n = 0;
      @(negedge clk28);
      bus_a = 16'hFBDF; bus_ioreq = 1'b1; bus_rd = 1'b1;
      #1;
      first = d_out;
      v = first;
      while (v == first && n < 1500) begin
         @(negedge clk28);
         #1;
         v = d_out;
         n++;
      end
      bus_ioreq = 1'b0; bus_rd = 1'b0;
      check("x held until commit", 32'(first), 32'(old_v));
      check("x after commit",      32'(v),     32'(new_v));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] old_x;
      rst = 1'b1; en = 1'b1; dev_clk = 1'b1; dev_dat = 1'b1;
      bus_a = 16'h0000; bus_ioreq = 1'b0; bus_rd = 1'b0;
      mdl_x = 8'h00; mdl_y = 8'h00; mdl_btn = 8'hFF;
      wait_cycles(5);
      check("reset clk_oe",    32'(ps2_clk_oe), 32'd0);
      check("reset dat_oe",    32'(ps2_dat_oe), 32'd0);
      check("reset streaming", 32'(streaming),  32'd0);
      rst = 1'b0;
      t_rel = $time;
      push_regs("reset");
      drain();

      host_handshake();
      dev_send(8'hFA, 1'b0);
      check("streaming after FA", 32'(streaming), 32'd1);

      send_packet("pkt1", 8'h09, 8'h10, 8'hFE);
      send_packet("pkt2", 8'h08, 8'h75, 8'h05);
      send_packet("xovf", 8'h48, 8'h20, 8'h04);

      dev_send(8'h09, 1'b0);
      dev_send(8'h30, 1'b1);
      dev_send(8'h02, 1'b0);
      send_packet("after parity err", 8'h0A, 8'h01, 8'h01);

      dev_partial(4);
      dev_send(8'h00, 1'b0);
      dev_send(8'h0C, 1'b0);
      dev_send(8'h7F, 1'b0);
      old_x = mdl_x;
      model_packet(8'h0C, 8'h7F, 8'hFF);
      fork
         dev_send(8'hFF, 1'b0);
         watch_commit(old_x, mdl_x);
      join
      push_regs("after resync");
      expect_read("en low",      16'hFBDF, 1'b0, 1'b0, 8'hFF);
      expect_read("port FCDF",   16'hFCDF, 1'b1, 1'b0, 8'hFF);
      drain();

      @(negedge clk28);
      rst = 1'b1;
      @(negedge clk28);
      rst = 1'b0;
      t_rel = $time;
      check("streaming cleared", 32'(streaming), 32'd0);
      wait_clk_oe();
      check_range("retry init delay", int'(($time - t_rel) / 10), INIT_DELAY - 2, INIT_DELAY + 2);
      measure_rts();
      begin
         int n = 0;
         while (ps2_dat_oe && n < TIMEOUT + 100) begin
            @(negedge clk28);
            n++;
         end
         check_range("no-ack timeout", n, TIMEOUT - 2, TIMEOUT + 2);
         check("clk released on timeout", 32'(ps2_clk_oe), 32'd0);
      end
      t_rel = $time;
      wait_clk_oe();
      check_range("re-rts after timeout", int'(($time - t_rel) / 10), INIT_DELAY - 2, INIT_DELAY + 2);
      wait_cycles(5);
      rst = 1'b1;
      @(negedge clk28);
      check("mid-rts reset clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("mid-rts reset dat_oe", 32'(ps2_dat_oe), 32'd0);
      rst = 1'b0;
      mdl_x = 8'h00; mdl_y = 8'h00; mdl_btn = 8'hFF;
      push_regs("post reset");
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
